// File: rtl/writeback_regfile.sv
// Writeback stage: 15x64 register file, condition codes and processor status.
// Optional macro WB_BYPASS_EN forwards same-cycle commit data onto valA/valB.
module writeback_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [3:0]  icode,
    input  logic        Cnd,
    input  logic        ZF_in,
    input  logic        SF_in,
    input  logic        OF_in,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    input  logic        imem_error,
    input  logic        dmem_error,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        ZF,
    output logic        SF,
    output logic        OF,
    output logic [1:0]  stat,
    output logic        halted
);
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_AOK = 2'b00,
        S_HLT = 2'b01,
        S_ADR = 2'b10,
        S_INS = 2'b11
    } stat_e;

    stat_e       stat_q, stat_d;
    logic [63:0] regs_q [0:14];
    logic [63:0] regs_d [0:14];
    logic        zf_q, zf_d, sf_q, sf_d, of_q, of_d;

    logic fault, commit, we_e, we_m, cc_we;

    // rst gates commit so no write or forward leaks out of a reset cycle
    assign fault  = imem_error || dmem_error || (icode > 4'hB);
    assign commit = instr_valid && (stat_q == S_AOK) && !fault && !rst;
    assign we_e   = commit && (dstE != RNONE) && !((icode == 4'h2) && !Cnd);
    assign we_m   = commit && (dstM != RNONE);
    assign cc_we  = commit && (icode == 4'h6);

    always_comb begin
        stat_d = stat_q;
        if (instr_valid && (stat_q == S_AOK)) begin
            if (imem_error || dmem_error) stat_d = S_ADR;
            else if (icode > 4'hB)        stat_d = S_INS;
            else if (icode == 4'h0)       stat_d = S_HLT;
            else                          stat_d = S_AOK;
        end
    end

    always_comb begin
        for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
        // valM written last so it wins when dstE == dstM
        if (we_e) regs_d[dstE] = valE;
        if (we_m) regs_d[dstM] = valM;
        zf_d = cc_we ? ZF_in : zf_q;
        sf_d = cc_we ? SF_in : sf_q;
        of_d = cc_we ? OF_in : of_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= S_AOK;
            zf_q   <= 1'b1;
            sf_q   <= 1'b0;
            of_q   <= 1'b0;
            for (int i = 0; i < 15; i++) regs_q[i] <= 64'h0;
        end else begin
            stat_q <= stat_d;
            zf_q   <= zf_d;
            sf_q   <= sf_d;
            of_q   <= of_d;
            for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
        end
    end

    function automatic logic [63:0] rd_port(input logic [3:0] src);
        logic [63:0] v;
        v = 64'h0;
        if (src != RNONE) begin
            v = regs_q[src];
`ifdef WB_BYPASS_EN
            if (we_m && (dstM == src))      v = valM;
            else if (we_e && (dstE == src)) v = valE;
`endif
        end
        return v;
    endfunction

    always_comb begin
        valA = rd_port(srcA);
        valB = rd_port(srcB);
    end

    assign ZF     = zf_q;
    assign SF     = sf_q;
    assign OF     = of_q;
    assign stat   = stat_q;
    assign halted = (stat_q != S_AOK);

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reference model compared every cycle
// plus hand-computed literal expectations.
module tb_writeback_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, Cnd, ZF_in, SF_in, OF_in, imem_error, dmem_error;
    logic [3:0]  icode, dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM, valA, valB;
    logic        ZF, SF, OF, halted;
    logic [1:0]  stat;

    int n_checks = 0;
    int n_errors = 0;

    writeback_regfile dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .icode(icode), .Cnd(Cnd),
        .ZF_in(ZF_in), .SF_in(SF_in), .OF_in(OF_in), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
        .imem_error(imem_error), .dmem_error(dmem_error),
        .valA(valA), .valB(valB), .ZF(ZF), .SF(SF), .OF(OF),
        .stat(stat), .halted(halted)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_reg [0:14];
    logic        m_zf, m_sf, m_of;
    logic [1:0]  m_stat;

    function automatic bit m_commit();
        return instr_valid && (m_stat == 2'b00) && !imem_error && !dmem_error
               && (icode <= 4'hB) && !rst;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) m_reg[i] <= 64'h0;
            m_zf <= 1'b1; m_sf <= 1'b0; m_of <= 1'b0; m_stat <= 2'b00;
        end else if (instr_valid && m_stat == 2'b00) begin
            if (imem_error || dmem_error) m_stat <= 2'b10;
            else if (icode > 4'hB)        m_stat <= 2'b11;
            else begin
                if (icode == 4'h0) m_stat <= 2'b01;
                if (dstE != 4'hF && !(icode == 4'h2 && !Cnd)) m_reg[dstE] <= valE;
                if (dstM != 4'hF) m_reg[dstM] <= valM;
                if (icode == 4'h6) begin
                    m_zf <= ZF_in; m_sf <= SF_in; m_of <= OF_in;
                end
            end
        end
    end

    function automatic logic [63:0] m_read(input logic [3:0] src);
        if (src == 4'hF) return 64'h0;
`ifdef WB_BYPASS_EN
        if (m_commit() && dstM == src) return valM;
        if (m_commit() && dstE == src && !(icode == 4'h2 && !Cnd)) return valE;
`endif
        return m_reg[src];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_valA", valA, m_read(srcA));
            check("cyc_valB", valB, m_read(srcB));
            check("cyc_cc", {61'h0, ZF, SF, OF}, {61'h0, m_zf, m_sf, m_of});
            check("cyc_stat", {62'h0, stat}, {62'h0, m_stat});
            check("cyc_halted", {63'h0, halted}, {63'h0, (m_stat != 2'b00)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        instr_valid = 0; icode = 4'h1; Cnd = 0; ZF_in = 0; SF_in = 0; OF_in = 0;
        dstE = 4'hF; dstM = 4'hF; valE = 64'h0; valM = 64'h0;
        imem_error = 0; dmem_error = 0;
    endtask

    task automatic commit(input logic [3:0] ic, input logic [3:0] de, input logic [3:0] dm,
                          input logic [63:0] ve, input logic [63:0] vm, input logic cnd,
                          input logic [2:0] flags, input logic dmerr);
        instr_valid = 1; icode = ic; dstE = de; dstM = dm; valE = ve; valM = vm; Cnd = cnd;
        {ZF_in, SF_in, OF_in} = flags; dmem_error = dmerr;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic read(input logic [3:0] a, input logic [3:0] b);
        srcA = a; srcB = b; #2;
    endtask

    task automatic pulse_rst();
        #1 rst = 1; #1 rst = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        idle(); srcA = 4'h0; srcB = 4'hF;
        rst = 1; #2;
        check("rst_stat", {62'h0, stat}, 64'h0);
        check("rst_zf", {63'h0, ZF}, 64'h1);
        check("rst_valA", valA, 64'h0);
        @(posedge clk); #1 rst = 0;

        // V1
        commit(4'h3, 4'h2, 4'hF, 64'h1234, 64'h0, 0, 3'b000, 0);
        read(4'h2, 4'hF);
        check("v1_valA", valA, 64'h1234);
        check("v1_valB", valB, 64'h0);

        // V2 cmov gating
        commit(4'h2, 4'h3, 4'hF, 64'hFF, 64'h0, 0, 3'b000, 0);
        read(4'h3, 4'h2);
        check("v2_untaken", valA, 64'h0);
        commit(4'h2, 4'h3, 4'hF, 64'hFF, 64'h0, 1, 3'b000, 0);
        read(4'h3, 4'h2);
        check("v2_taken", valA, 64'hFF);

        // V3 dstE==dstM and CC update/hold
        commit(4'h5, 4'h4, 4'h4, 64'h10, 64'h20, 0, 3'b000, 0);
        read(4'h4, 4'h3);
        check("v3_mwins", valA, 64'h20);
        commit(4'h6, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'b010, 0);
        #2 check("v3_cc_set", {61'h0, ZF, SF, OF}, 64'h2);
        commit(4'h3, 4'h6, 4'hF, 64'h7, 64'h0, 0, 3'b101, 0);
        #2 check("v3_cc_hold", {61'h0, ZF, SF, OF}, 64'h2);

        // instr_valid=0 leaves state unchanged
        instr_valid = 0; icode = 4'h6; dstE = 4'h2; valE = 64'hDEAD; {ZF_in, SF_in, OF_in} = 3'b111;
        @(posedge clk); #1 idle();
        read(4'h2, 4'h6);
        check("nv_reg", valA, 64'h1234);
        check("nv_reg6", valB, 64'h7);

        // V6 same-cycle read of committing register
        instr_valid = 1; icode = 4'h3; dstE = 4'h5; valE = 64'hAB; srcA = 4'h5; #2;
`ifdef WB_BYPASS_EN
        check("v6_bypass", valA, 64'hAB);
`else
        check("v6_nobypass", valA, 64'h0);
`endif
        @(posedge clk); #1 idle();
        read(4'h5, 4'hF);
        check("v6_after", valA, 64'hAB);

        // V4 illegal instruction, sticky
        commit(4'hC, 4'h1, 4'hF, 64'h5, 64'h0, 0, 3'b000, 0);
        read(4'h1, 4'h5);
        check("v4_stat_ins", {62'h0, stat}, 64'h3);
        check("v4_halted", {63'h0, halted}, 64'h1);
        check("v4_reg1", valA, 64'h0);
        commit(4'h3, 4'h1, 4'hF, 64'h9, 64'h0, 0, 3'b000, 0);
        read(4'h1, 4'h5);
        check("v4_ignored", valA, 64'h0);
        check("v4_sticky", {62'h0, stat}, 64'h3);
        pulse_rst();
        commit(4'hC, 4'h1, 4'hF, 64'h5, 64'h0, 0, 3'b000, 1);
        #2 check("v4_adr", {62'h0, stat}, 64'h2);

        // V5 halt then mid-cycle reset
        pulse_rst();
        commit(4'h3, 4'h7, 4'hF, 64'h55, 64'h0, 0, 3'b000, 0);
        commit(4'h6, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'b001, 0);
        commit(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'b000, 0);
        read(4'h7, 4'hF);
        check("v5_hlt", {62'h0, stat}, 64'h1);
        check("v5_reg7", valA, 64'h55);
        @(negedge clk); #2 rst = 1; #1;
        check("v5_rst_stat", {62'h0, stat}, 64'h0);
        check("v5_rst_zf", {61'h0, ZF, SF, OF}, 64'h4);
        check("v5_rst_reg", valA, 64'h0);
        check("v5_rst_halted", {63'h0, halted}, 64'h0);
        #1 rst = 0;
        commit(4'h3, 4'h8, 4'hF, 64'h77, 64'h0, 0, 3'b000, 0);
        read(4'h8, 4'h7);
        check("v5_first_commit", valA, 64'h77);

        // reset held across a commit edge aborts the write
        instr_valid = 1; icode = 4'h3; dstE = 4'h9; valE = 64'h99; rst = 1;
        @(posedge clk); #1 rst = 0; idle();
        read(4'h9, 4'h8);
        check("abort_reg9", valA, 64'h0);
        check("abort_reg8", valB, 64'h0);

        repeat (2) @(posedge clk);
        #1 $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have a single clock, clk (rising edge); reset rst is asynchronous and active-high.
REQ-002 SHALL expose ports, one per line (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  async active-high reset
  instr_valid  in  1  one completed instruction presented this cycle
  icode  in  4  instruction code of presented instruction
  Cnd  in  1  condition result from execute
  ZF_in / SF_in / OF_in  in  1 each  flags from execute ALU
  dstE / dstM  in  4 each  destination register IDs; 4'hF = none
  valE / valM  in  64 each  ALU result / memory-read result
  srcA / srcB  in  4 each  read register IDs
  imem_error / dmem_error  in  1 each  fetch / data-memory fault for presented instruction
  valA / valB  out  64 each  read data for srcA / srcB
  ZF / SF / OF  out  1 each  registered condition codes
  stat  out  2  processor status: 00 AOK, 01 HLT, 10 ADR, 11 INS
  halted  out  1  high when stat != AOK

Function
REQ-003 SHALL hold 15 registers of 64 bits, IDs 0x0-0xE; ID 0xF is not storage.
REQ-004 SHALL drive valA/valB combinationally from srcA/srcB; ID 0xF reads 64'h0.
REQ-005 An instruction commits when instr_valid=1, stat=AOK and no fault is classified for it (REQ-011); only committing instructions change state.
REQ-006 On a commit edge, SHALL write valE to dstE when dstE!=0xF, except when icode=4'h2 and Cnd=0 (untaken cmov: no dstE write).
REQ-007 On a commit edge, SHALL write valM to dstM when dstM!=0xF.
REQ-008 dstE==dstM (not 0xF) on the same commit: valM SHALL be written; valE discarded.
REQ-009 On a commit edge with icode=4'h6, SHALL load ZF/SF/OF from ZF_in/SF_in/OF_in; otherwise CC SHALL hold.
REQ-010 Register writes and CC updates SHALL be visible on outputs the cycle after the commit edge (1-cycle latency), subject to REQ-016.
REQ-011 Status state machine, states AOK, HLT, ADR, INS; on an instr_valid edge in AOK, next state by priority: imem_error or dmem_error -> ADR; icode>4'hB -> INS; icode=4'h0 -> HLT; else AOK.
REQ-012 A faulting instruction (ADR/INS) SHALL write no registers and no CC; a halt writes nothing (dst=0xF by decode) and is the last commit.
REQ-013 HLT, ADR, INS SHALL be sticky until rst; in them instr_valid and all data inputs are ignored.
REQ-014 instr_valid=0 SHALL leave all state unchanged.
REQ-015 halted SHALL equal (stat!=AOK), decoded from the state register (no combinational path from inputs).

Reset
REQ-016 rst asserted SHALL immediately, independent of clk, set all 15 registers to 0, ZF=1, SF=0, OF=0, stat=AOK, halted=0; valA/valB then read 0.
REQ-017 rst asserted mid-operation SHALL abort any in-flight commit; no write from that cycle survives; first commit possible on the first clk edge after rst deasserts.

Configuration
REQ-018 Macro WB_BYPASS_EN: when defined, valA/valB SHALL forward same-cycle commit data (valM over valE per REQ-008, cmov gating per REQ-006) when srcA/srcB matches a committing dstE/dstM; when undefined, valA/valB SHALL return the pre-edge stored value.

Verification
REQ-019 Bench SHALL cover:
  V1: commit icode=3, dstE=0x2, valE=64'h1234 -> next cycle srcA=0x2 gives valA=64'h1234; srcB=0xF gives valB=0.
  V2: icode=2, Cnd=0, dstE=0x3, valE=64'hFF -> reg 3 unchanged (0); repeat with Cnd=1 -> reg 3=64'hFF.
  V3: icode=5, dstE=dstM=0x4, valE=64'h10, valM=64'h20 -> reg 4=64'h20; icode=6 with ZF_in=0,SF_in=1,OF_in=0 -> ZF=0,SF=1,OF=0; following icode=3 leaves CC unchanged.
  V4: icode=4'hC with dstE=0x1, valE=5 -> stat=11, halted=1, reg 1=0; later valid icode=3 writes ignored; dmem_error=1 with icode=4'hC from AOK -> stat=10.
  V5: icode=0 -> stat=01 next cycle; rst pulsed between clk edges -> stat=00, all regs 0, ZF=1 immediately.
  V6: same cycle commit dstE=0x5, valE=64'hAB, srcA=0x5 -> valA=64'hAB with WB_BYPASS_EN, 0 without.
